// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI-slave front end.
package spi_slave_pkg;

   localparam int unsigned ADDR_SIZE = 8;
   localparam int unsigned DATA_W    = ADDR_SIZE;
   localparam int unsigned WORD_W    = ADDR_SIZE + 2;
   localparam int unsigned CNT_W     = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // Command word as seen by the RAM: 2-bit opcode above the payload.
   typedef struct packed {
      logic [1:0]        cmd;
      logic [DATA_W-1:0] payload;
   } rx_word_t;

   // True when a completed word's opcode is legal for the state that received it.
   function automatic logic cmd_allowed(state_e st, logic [1:0] cmd);
      case (st)
         WRITE:     return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
         READ_ADD:  return (cmd == CMD_RD_ADDR);
         READ_DATA: return (cmd == CMD_RD_DATA);
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/spi_slave_fsm_if.sv
// Serial-side and RAM-side signals of the SPI slave front end.
interface spi_slave_fsm_if;
   import spi_slave_pkg::*;

   logic              SS_n;
   logic              MOSI;
   logic              MISO;
   logic [WORD_W-1:0] rx_data;
   logic              rx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;

   // The slave is the front end; the master side is the SPI host plus RAM.
   modport slave (
      input  SS_n, MOSI, tx_data, tx_valid,
      output MISO, rx_data, rx_valid
   );

   modport master (
      output SS_n, MOSI, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid
   );
endinterface

// File: rtl/spi_tx_serializer.sv
// MSB-first read-data shifter: loads on request, emits DATA_W bits, then
// raises done and returns the line to 0.
module spi_tx_serializer
   import spi_slave_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              miso,
   output logic              busy,
   output logic              done
);

   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;

   // Load, shift out one bit per edge, then drop the line; clear aborts at once.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         shreg <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         miso  <= 1'b0;
      end else if (load) begin
         shreg <= data;
         cnt   <= CNT_W'(DATA_W);
         busy  <= 1'b1;
         done  <= 1'b0;
         miso  <= 1'b0;
      end else if (busy) begin
         if (cnt != '0) begin
            miso  <= shreg[DATA_W-1];
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) done <= 1'b1;
         end else begin
            miso <= 1'b0;
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave command sequencer: deserialises MOSI words for the RAM and
// serialises read data back on MISO.
// Optional build macro SPI_CMD_CHECK_EN: reject words whose opcode does not
// match the state that received them.
module spi_slave_fsm
   import spi_slave_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   spi_slave_fsm_if.slave bus
);

   state_e              state;
   logic [WORD_W-2:0]   shift_reg;
   logic [CNT_W-1:0]    bit_cnt;
   logic [WORD_W-1:0]   rx_data_q;
   logic                rx_valid_q;
   logic                rd_addr_flag;
   logic                word_done;
   logic                word_ok;

   rx_word_t            word_c;
   logic                last_bit_c;
   logic                cmd_ok_c;
   logic                tx_load_c;

   logic                ser_miso;
   logic                ser_busy;
   logic                ser_done;

   // Word assembled if the current MOSI bit is the last one.
   always_comb begin
      word_c     = rx_word_t'({shift_reg, bus.MOSI});
      last_bit_c = (bit_cnt == CNT_W'(WORD_W - 1));
`ifdef SPI_CMD_CHECK_EN
      cmd_ok_c   = cmd_allowed(state, word_c.cmd);
`else
      cmd_ok_c   = 1'b1;
`endif
      tx_load_c  = (state == READ_DATA) && word_done && word_ok &&
                   !ser_busy && !ser_done && bus.tx_valid;
   end

   // Frame sequencer: command decode, word shift-in and read-address flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rd_addr_flag <= 1'b0;
         word_done    <= 1'b0;
         word_ok      <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (bus.SS_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            word_ok   <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= CHK_CMD;
               CHK_CMD: begin
                  bit_cnt   <= '0;
                  shift_reg <= '0;
                  word_done <= 1'b0;
                  word_ok   <= 1'b0;
                  if (!bus.MOSI)         state <= WRITE;
                  else if (!rd_addr_flag) state <= READ_ADD;
                  else                   state <= READ_DATA;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (!word_done) begin
                     if (last_bit_c) begin
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        word_done <= 1'b1;
                        word_ok   <= cmd_ok_c;
                        if (cmd_ok_c) begin
                           rx_data_q  <= word_c;
                           rx_valid_q <= 1'b1;
                           if (state == READ_ADD) rd_addr_flag <= 1'b1;
                        end
                     end else begin
                        shift_reg <= {shift_reg[WORD_W-3:0], bus.MOSI};
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                     end
                  end else if ((state == READ_DATA) && ser_done) begin
                     rd_addr_flag <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   spi_tx_serializer u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.SS_n),
      .load  (tx_load_c),
      .data  (bus.tx_data),
      .miso  (ser_miso),
      .busy  (ser_busy),
      .done  (ser_done)
   );

   assign bus.MISO     = ser_miso;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: write, read, abort, reset and opcode check.
module tb_spi_slave_fsm;
   import spi_slave_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors  = 0;
   int   errors   = 0;
   int   rxv_cnt  = 0;
   int   miso_cnt = 0;

   spi_slave_fsm_if bus();

   spi_slave_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // One clock: drive on the falling edge, observe 1 ns after the rising edge.
   task automatic step(input logic ss, input logic mosi, input logic tv);
      @(negedge clk);
      bus.SS_n     = ss;
      bus.MOSI     = mosi;
      bus.tx_valid = tv;
      @(posedge clk);
      #1;
      if (bus.rx_valid) rxv_cnt++;
      if (bus.MISO)     miso_cnt++;
   endtask

   // Edges 0..11: select, command bit, then 10 word bits MSB first.
   task automatic send_word(input logic cmd, input logic [9:0] w);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, cmd, 1'b0);
      for (int i = 9; i >= 0; i--) step(1'b0, w[i], 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %0b expected 0", bus.rx_valid); end
      vectors++;
      if (bus.rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data: got %0h expected 0", bus.rx_data); end
      vectors++;
      if (bus.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %0b expected 0", bus.MISO); end
      vectors++;
      if (dut.rd_addr_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %0b expected 0", dut.rd_addr_flag); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write_addr();
      rxv_cnt = 0; miso_cnt = 0;
      send_word(1'b0, 10'h0A5);
      vectors++;
      if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL wa_strobe: got %0b expected 1", bus.rx_valid); end
      vectors++;
      if (bus.rx_data !== 10'h0A5) begin errors++; $display("FAIL wa_data: got %0h expected 0a5", bus.rx_data); end
      repeat (3) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if (rxv_cnt !== 1) begin errors++; $display("FAIL wa_pulses: got %0d expected 1", rxv_cnt); end
      vectors++;
      if (miso_cnt !== 0) begin errors++; $display("FAIL wa_miso: got %0d high cycles expected 0", miso_cnt); end
      vectors++;
      if (dut.state !== IDLE) begin errors++; $display("FAIL wa_idle: got %0d expected %0d", dut.state, IDLE); end
   endtask

   task automatic test_write_data();
      rxv_cnt = 0; miso_cnt = 0;
      send_word(1'b0, 10'h13C);
      vectors++;
      if (bus.rx_data !== 10'h13C) begin errors++; $display("FAIL wd_data: got %0h expected 13c", bus.rx_data); end
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL wd_one_cycle: got %0b expected 0", bus.rx_valid); end
      // tx_valid outside a read-data wait must not reach MISO
      bus.tx_data = 8'hFF;
      repeat (4) step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if (miso_cnt !== 0) begin errors++; $display("FAIL wd_tx_ignored: got %0d high cycles expected 0", miso_cnt); end
      vectors++;
      if (bus.rx_data !== 10'h13C) begin errors++; $display("FAIL wd_hold: got %0h expected 13c", bus.rx_data); end
   endtask

   task automatic test_read_seq();
      logic [7:0] got;
      rxv_cnt = 0; miso_cnt = 0;
      send_word(1'b1, 10'h207);
      vectors++;
      if (bus.rx_data !== 10'h207) begin errors++; $display("FAIL ra_data: got %0h expected 207", bus.rx_data); end
      vectors++;
      if (dut.rd_addr_flag !== 1'b1) begin errors++; $display("FAIL ra_flag: got %0b expected 1", dut.rd_addr_flag); end
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if (dut.rd_addr_flag !== 1'b1) begin errors++; $display("FAIL ra_flag_kept: got %0b expected 1", dut.rd_addr_flag); end
      send_word(1'b1, 10'h35A);
      vectors++;
      if (bus.rx_data !== 10'h35A) begin errors++; $display("FAIL rd_data: got %0h expected 35a", bus.rx_data); end
      repeat (2) step(1'b0, 1'b0, 1'b0);
      bus.tx_data = 8'hC3;
      step(1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rd_load_edge: got %0b expected 0", bus.MISO); end
      bus.tx_data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b0);
         got[7-i] = bus.MISO;
      end
      vectors++;
      if (got !== 8'hC3) begin errors++; $display("FAIL rd_miso_bits: got %0h expected c3", got); end
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rd_miso_idle: got %0b expected 0", bus.MISO); end
      vectors++;
      if (dut.rd_addr_flag !== 1'b0) begin errors++; $display("FAIL rd_flag_clr: got %0b expected 0", dut.rd_addr_flag); end
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if (rxv_cnt !== 2) begin errors++; $display("FAIL rd_pulses: got %0d expected 2", rxv_cnt); end
   endtask

   task automatic test_abort();
      rxv_cnt = 0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if (dut.state !== IDLE) begin errors++; $display("FAIL ab_idle: got %0d expected %0d", dut.state, IDLE); end
      vectors++;
      if (rxv_cnt !== 0) begin errors++; $display("FAIL ab_no_strobe: got %0d expected 0", rxv_cnt); end
      vectors++;
      if (bus.rx_data !== 10'h35A) begin errors++; $display("FAIL ab_rx_hold: got %0h expected 35a", bus.rx_data); end
      send_word(1'b0, 10'h05A);
      vectors++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h05A) begin
         errors++; $display("FAIL ab_next_frame: got valid=%0b data=%0h expected valid=1 data=05a", bus.rx_valid, bus.rx_data);
      end
      step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_read();
      send_word(1'b1, 10'h211);
      step(1'b1, 1'b0, 1'b0);
      send_word(1'b1, 10'h3C0);
      bus.tx_data = 8'hC3;
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.MISO !== 1'b1) begin errors++; $display("FAIL rr_pre_miso: got %0b expected 1", bus.MISO); end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rr_miso: got %0b expected 0", bus.MISO); end
      vectors++;
      if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rr_rx_valid: got %0b expected 0", bus.rx_valid); end
      vectors++;
      if (dut.rd_addr_flag !== 1'b0) begin errors++; $display("FAIL rr_flag: got %0b expected 0", dut.rd_addr_flag); end
      vectors++;
      if (dut.state !== IDLE) begin errors++; $display("FAIL rr_state: got %0d expected %0d", dut.state, IDLE); end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_cmd_check();
      rxv_cnt = 0;
      send_word(1'b0, 10'h301);
      step(1'b1, 1'b0, 1'b0);
`ifdef SPI_CMD_CHECK_EN
      vectors++;
      if (rxv_cnt !== 0) begin errors++; $display("FAIL cc_reject: got %0d pulses expected 0", rxv_cnt); end
`else
      vectors++;
      if (rxv_cnt !== 1) begin errors++; $display("FAIL cc_pass: got %0d pulses expected 1", rxv_cnt); end
      vectors++;
      if (bus.rx_data !== 10'h301) begin errors++; $display("FAIL cc_data: got %0h expected 301", bus.rx_data); end
`endif
   endtask

   initial begin
      test_reset();
      test_write_addr();
      test_write_data();
      test_read_seq();
      test_abort();
      test_reset_mid_read();
      test_cmd_check();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
